// File: rtl/rr_mux4_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux4_arbiter
//
// Round-robin arbiter and sequencer for a shared 4-to-1 single-bit channel.
// One requester at a time is granted for a burst of at most MAX_BURST
// transfers. The block drives the mux select and forwards the granted
// requester's data bit to `out`, qualified by `valid`.
//
// Parameters:
//   MAX_BURST  maximum transfers per grant (1..15)
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   req    in   [0:3] request, bit i = requester i
//   in     in   [0:3] data bit, bit i = requester i
//   sel    out  [0:1] registered binary index of the granted requester
//   gnt    out  [0:3] registered one-hot grant, bit i = requester i; 0 when idle
//   valid  out  combinational, a transfer happens this cycle
//   out    out  combinational, in[sel] while valid, else 0
// -----------------------------------------------------------------------------
module rr_mux4_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:3] req,
    input  logic [0:3] in,
    output logic [0:1] sel,
    output logic [0:3] gnt,
    output logic       valid,
    output logic       out
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Transfer count at which the current transfer is the last of the burst.
    localparam logic [3:0] LAST_CNT = 4'(MAX_BURST - 1);

    state_t     state, state_next;
    logic [1:0] ptr, ptr_next;       // index searched first
    logic [1:0] sel_q, sel_next;
    logic [3:0] cnt, cnt_next;       // transfers done in the current grant
    logic [3:0] gnt_q, gnt_next;     // bit i = requester i

    logic       cur_req;
    logic       release_now;
    logic [1:0] search_base;
    logic [1:0] win;
    logic       win_found;

    // -------------------------------------------------------------------------
    // Datapath toward the shared line
    // -------------------------------------------------------------------------
    assign cur_req = req[sel_q];
    assign valid   = (state == GRANT) && cur_req;
    assign out     = valid && in[sel_q];

    // A grant ends when the owner withdraws, or on its final burst transfer.
    assign release_now = (state == GRANT) && (!cur_req || (cnt == LAST_CNT));

    // On release the pointer moves past the current owner, and the search for
    // the follow-on grant already uses that new pointer, so the releasing
    // requester is considered last.
    assign search_base = release_now ? sel_q + 2'd1 : ptr;

    // -------------------------------------------------------------------------
    // Winner search: first requester at search_base, +1, +2, +3 (mod 4).
    // Scanning from the farthest offset down leaves the nearest one in `win`.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [1:0] idx;
        win       = search_base;
        win_found = 1'b0;
        idx       = search_base;
        for (int k = 3; k >= 0; k--) begin
            idx = search_base + 2'(k);
            if (req[idx]) begin
                win       = idx;
                win_found = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        sel_next   = sel_q;
        cnt_next   = cnt;
        gnt_next   = gnt_q;

        case (state)
            IDLE: begin
                if (win_found) begin
                    state_next = GRANT;
                    sel_next   = win;
                    cnt_next   = 4'd0;
                    gnt_next   = 4'b0001 << win;
                end
            end

            GRANT: begin
                if (release_now) begin
                    ptr_next = sel_q + 2'd1;
                    cnt_next = 4'd0;
                    if (win_found) begin
                        // Back-to-back handover, no idle bubble.
                        sel_next = win;
                        gnt_next = 4'b0001 << win;
                    end else begin
                        // sel keeps its last value while idle.
                        state_next = IDLE;
                        gnt_next   = 4'b0000;
                    end
                end else if (valid) begin
                    cnt_next = cnt + 4'd1;
                end
            end

            default: begin
                state_next = IDLE;
                gnt_next   = 4'b0000;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers; reset wins over any release or transfer at the same edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            sel_q <= 2'd0;
            cnt   <= 4'd0;
            gnt_q <= 4'b0000;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            sel_q <= sel_next;
            cnt   <= cnt_next;
            gnt_q <= gnt_next;
        end
    end

    // Select is exported as a binary value.
    assign sel = sel_q;

    // Internal grant bit i maps to port bit i (requester i).
    for (genvar i = 0; i < 4; i++) begin : g_gnt
        assign gnt[i] = gnt_q[i];
    end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for rr_mux4_arbiter. Two instances: MAX_BURST=4 and MAX_BURST=1.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Expected values are queued as stimulus is driven and popped
// when the cycle's outputs are sampled.
// -----------------------------------------------------------------------------
module tb_rr_mux4_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:3] req, in, gnt;
    logic [0:1] sel;
    logic       valid, out;

    logic [0:3] req1, in1, gnt1;
    logic [0:1] sel1;
    logic       valid1, out1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] g;   // grant value as written, leftmost = requester 0
        logic [1:0] s;
        logic       v;
        logic       o;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    rr_mux4_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .in(in),
        .sel(sel), .gnt(gnt), .valid(valid), .out(out)
    );

    rr_mux4_arbiter #(.MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .in(in1),
        .sel(sel1), .gnt(gnt1), .valid(valid1), .out(out1)
    );

    function automatic exp_t mk(logic [3:0] g, logic [1:0] s, logic v, logic o);
        exp_t e;
        e.g = g; e.s = s; e.v = v; e.o = o;
        return e;
    endfunction

    // One-hot grant value for requester r (requester 0 is the leftmost bit).
    function automatic logic [3:0] oh(int r);
        logic [3:0] base;
        base = 4'b1000;
        return base >> r;
    endfunction

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1; req = 4'b0000; req1 = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; req = 4'b1111; in = 4'b1111; req1 = 4'b0000; in1 = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            if (c == 1) rst = 1'b0;
            exp_q.push_back(mk(4'b0000, 2'b00, 1'b0, 1'b0));
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({gnt, sel, valid, out} !== {e.g, e.s, e.v, e.o}) begin
                failures++;
                $display("FAIL reset c%0d: got gnt=%b sel=%b valid=%b out=%b, want gnt=%b sel=%b valid=%b out=%b",
                         c, gnt, sel, valid, out, e.g, e.s, e.v, e.o);
            end
        end
        @(posedge clk); #1;
        exp_q.push_back(mk(4'b1000, 2'b00, 1'b1, in[0]));
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({gnt, sel, valid, out} !== {e.g, e.s, e.v, e.o}) begin
            failures++;
            $display("FAIL reset_release: got gnt=%b sel=%b valid=%b out=%b, want gnt=%b sel=%b valid=%b out=%b",
                     gnt, sel, valid, out, e.g, e.s, e.v, e.o);
        end
    endtask

    // Requester 2 alone: two full bursts back to back, then one more transfer.
    task automatic test_single();
        exp_t e;
        apply_reset();
        req = 4'b0010; in = 4'b0010;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            in = (c == 5) ? 4'b0000 : 4'b0010;
            exp_q.push_back(mk(4'b0010, 2'b10, 1'b1, in[2]));
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({gnt, sel, valid, out} !== {e.g, e.s, e.v, e.o}) begin
                failures++;
                $display("FAIL single c%0d: got gnt=%b sel=%b valid=%b out=%b, want gnt=%b sel=%b valid=%b out=%b",
                         c, gnt, sel, valid, out, e.g, e.s, e.v, e.o);
            end
        end
    endtask

    // Continues from test_single: requester 2 is in its 3rd burst with the
    // pointer at 3, so only a cleared pointer makes requester 2 win over 3.
    task automatic test_reset_mid_grant();
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            case (c)
                0: begin rst = 1'b1; in = 4'b1111; exp_q.push_back(mk(4'b0010, 2'b10, 1'b1, 1'b1)); end
                1: begin rst = 1'b0; req = 4'b0011; exp_q.push_back(mk(4'b0000, 2'b00, 1'b0, 1'b0)); end
                default: exp_q.push_back(mk(4'b0010, 2'b10, 1'b1, 1'b1));
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({gnt, sel, valid, out} !== {e.g, e.s, e.v, e.o}) begin
                failures++;
                $display("FAIL reset_mid c%0d: got gnt=%b sel=%b valid=%b out=%b, want gnt=%b sel=%b valid=%b out=%b",
                         c, gnt, sel, valid, out, e.g, e.s, e.v, e.o);
            end
        end
    endtask

    // Everyone requests: 0,1,2,3,0, four transfers each.
    task automatic test_all_requesting();
        exp_t e;
        int   r;
        apply_reset();
        req = 4'b1111;
        for (int c = 0; c < 21; c++) begin
            @(posedge clk); #1;
            in = 4'($urandom_range(0, 15));
            r  = (c / 4) % 4;
            exp_q.push_back(mk(oh(r), 2'(r), 1'b1, in[r]));
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({gnt, sel, valid, out} !== {e.g, e.s, e.v, e.o}) begin
                failures++;
                $display("FAIL all_req c%0d: got gnt=%b sel=%b valid=%b out=%b, want gnt=%b sel=%b valid=%b out=%b",
                         c, gnt, sel, valid, out, e.g, e.s, e.v, e.o);
            end
        end
    endtask

    // Requester 1 drops after 2 transfers; requester 3 then gets a full burst
    // even though requester 1 re-requests during it.
    task automatic test_withdraw();
        exp_t e;
        int   who;
        logic v;
        apply_reset();
        req = 4'b0101; in = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            req = (c == 2 || c == 3) ? 4'b0001 : 4'b0101;
            who = (c < 3) ? 1 : (c < 7) ? 3 : 1;
            v   = (c != 2);
            exp_q.push_back(mk(oh(who), 2'(who), v, v & in[who]));
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({gnt, sel, valid, out} !== {e.g, e.s, e.v, e.o}) begin
                failures++;
                $display("FAIL withdraw c%0d: got gnt=%b sel=%b valid=%b out=%b, want gnt=%b sel=%b valid=%b out=%b",
                         c, gnt, sel, valid, out, e.g, e.s, e.v, e.o);
            end
        end
    endtask

    // MAX_BURST=1: 0 and 3 alternate every cycle, then both drop and the
    // block idles with sel holding 3.
    task automatic test_burst1();
        exp_t e;
        int   who;
        apply_reset();
        req1 = 4'b1001;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            in1  = 4'($urandom_range(0, 15));
            req1 = (c >= 5) ? 4'b0000 : 4'b1001;
            who  = (c % 2 == 0) ? 0 : 3;
            if (c < 5)       exp_q.push_back(mk(oh(who), 2'(who), 1'b1, in1[who]));
            else if (c == 5) exp_q.push_back(mk(oh(3), 2'b11, 1'b0, 1'b0));
            else             exp_q.push_back(mk(4'b0000, 2'b11, 1'b0, 1'b0));
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({gnt1, sel1, valid1, out1} !== {e.g, e.s, e.v, e.o}) begin
                failures++;
                $display("FAIL burst1 c%0d: got gnt=%b sel=%b valid=%b out=%b, want gnt=%b sel=%b valid=%b out=%b",
                         c, gnt1, sel1, valid1, out1, e.g, e.s, e.v, e.o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid_grant();
        test_all_requesting();
        test_withdraw();
        test_burst1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_mux4_arbiter.md
# rr_mux4_arbiter

Round-robin arbiter and sequencer for a shared 4-to-1 single-bit mux channel. Four requesters contend for one output line; the block grants one requester at a time for a bounded burst, drives the 2-bit mux select, and forwards the granted requester's data bit to `out` with a `valid` qualifier. It sits between the requester slots and the shared downstream line, replacing free-running select logic with fair, registered scheduling.

## Interface

- `MAX_BURST`, default 4: maximum transfers per grant; legal range 1..15.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset; one clock, synchronous, active-high.
- `req`  input  [0:3]  request per requester; bit i belongs to requester i.
- `in`  input  [0:3]  data bit per requester; bit i belongs to requester i.
- `sel`  output  [0:1]  registered mux select; binary index of the granted requester.
- `gnt`  output  [0:3]  registered one-hot grant; all zero when idle.
- `valid`  output  1  combinational: a transfer occurs this cycle.
- `out`  output  1  combinational: `in[sel]` when `valid`, else 0.

## Operation

- State machine with two states, IDLE and GRANT. Internal registers: `ptr` (2 bits, next-priority index) and `cnt` (4 bits, transfers in current grant).
- Winner search: scan indices `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4). The first index with `req` set wins.
- IDLE behaviour:
  - `gnt` is 0000 and `valid` is 0.
  - If any `req` bit is set at a clock edge: go to GRANT, load `sel` with the winner, set `gnt` to the winner's one-hot code, clear `cnt`.
- GRANT behaviour:
  - `valid` equals `req[sel]`; `out` equals `in[sel]` when `valid` is 1.
  - A transfer is any cycle with `valid` = 1. Each transfer increments `cnt`.
- Release happens at the edge where either:
  - `req[sel]` = 0 (requester withdrew; no transfer that cycle), or
  - a transfer occurs with `cnt` = `MAX_BURST`-1.
- On release:
  - `ptr` is loaded with `sel`+1 mod 4 (3 wraps to 0).
  - The winner search is rerun with the new `ptr`, using the current `req` value.
  - If there is a winner, the new grant starts on the next cycle with no idle bubble, and `cnt` clears.
  - If no `req` bit is set, go to IDLE.
- The releasing requester is searched last. If it is the only requester still asserting `req`, it is regranted back-to-back.
- `req` changes on non-granted requesters during GRANT do not affect the current grant.
- `MAX_BURST` = 1: every transfer releases.

## Timing

- Reset values: state IDLE, `ptr` 0, `cnt` 0, `sel` 00, `gnt` 0000, `valid` 0, `out` 0.
- `rst` takes effect at the edge where it is sampled high. An active grant ends immediately, and no transfer is counted in that cycle.
- `rst` overrides all other events at the same edge.
- Grant latency: `req` sampled at edge k in IDLE causes `gnt`/`sel` to change after edge k (one cycle). `valid` can be 1 in the cycle following edge k.
- `out`/`valid` have zero latency from `in`/`req` while granted; they are combinational through the mux.
- Back-to-back grants: `sel`/`gnt` switch on the release edge. No cycle exists with `gnt` = 0000 while any `req` is pending.
- `gnt` is always one-hot or zero. `sel` holds its last value in IDLE.
- Worst-case wait for a continuously requesting port: 3×`MAX_BURST` transfer cycles plus grant switches.

## Test plan

- Reset: drive `rst`=1 for 2 cycles with `req`=1111 → `gnt`=0000, `sel`=00, `valid`=0, `out`=0; `gnt`=1000 one cycle after `rst` falls.
- Single requester, `MAX_BURST`=4:
  - Stimulus: `req`=0010 held, `in`=0010.
  - Response: `gnt`=0010, `sel`=10, `valid`=1, `out`=1 for 4 cycles, then regrant to requester 2 back-to-back with `cnt` restarted. No idle cycle.
- All requesting, `MAX_BURST`=4:
  - Stimulus: `req`=1111 held.
  - Response: grant order 0,1,2,3,0, each for exactly 4 `valid` cycles. `sel` sequence 00,01,10,11,00, confirming the `ptr` wrap from 3 to 0.
- Early withdrawal:
  - Stimulus: `req`=0101; requester 1 drops `req` after 2 transfers.
  - Response: one non-valid cycle, then `gnt`=0001, `sel`=11 on the next cycle. Requester 3 receives a full 4-transfer burst.
- Reset mid-grant:
  - Stimulus: assert `rst` during the 2nd transfer of requester 2.
  - Response: next cycle `gnt`=0000, `ptr`=0. After release with `req`=0011, requester 2 is granted first, not requester 3.
- `MAX_BURST`=1, `req`=1001 → grants alternate 0,3,0,3 every cycle, with `valid`=1 continuously.
